// File: rtl/sample_scheduler.sv
// Round-robin owner of one shared sampling-interval timer with a free-running tick prescaler.
// Optional build macro SAMPLE_SCHEDULER_RELEASE_ABORT_EN: releasing req_i cancels the active interval.
module sample_scheduler #(
   parameter int WORD_LENGTH        = 16,
   parameter int SYSTEM_FREQUENCY   = 100000000,
   parameter int SAMPLING_FREQUENCY = 1000000,
   parameter int NUM_REQ            = 4
) (
   input  logic                           clock_i,
   input  logic                           reset_n_i,
   input  logic                           enable_i,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ*WORD_LENGTH-1:0] interval_i,
   input  logic                           abort_i,
   output logic                           tick_o,
   output logic [NUM_REQ-1:0]             grant_o,
   output logic [NUM_REQ-1:0]             done_o,
   output logic                           busy_o,
   output logic [WORD_LENGTH-1:0]         count_o
);

   localparam int DIVIDE = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
   localparam int PW     = $clog2(DIVIDE);
   localparam int IW     = $clog2(NUM_REQ);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIVIDE - 1);
   localparam logic [PW-1:0] PRESC_PRE  = PW'(DIVIDE - 2);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [PW-1:0]          r_presc;
   logic                   r_tick;
   logic [NUM_REQ-1:0]     r_grant;
   logic [IW-1:0]          r_grant_idx;
   logic [IW-1:0]          r_last;
   logic [WORD_LENGTH-1:0] r_interval;
   logic [WORD_LENGTH-1:0] r_count;

   logic                   w_tick;
   logic                   w_sel_found;
   logic [IW-1:0]          w_sel_idx;
   logic [NUM_REQ-1:0]     w_sel_onehot;
   logic [WORD_LENGTH-1:0] w_sel_interval;
   logic [WORD_LENGTH-1:0] w_count_inc;
   logic                   w_release;
   logic                   w_cancel;
   logic                   w_complete;
   logic [NUM_REQ-1:0]     w_done;

   // Requester index `offset` positions above `base`, wrapping at NUM_REQ.
   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
      return IW'((int'(base) + offset) % NUM_REQ);
   endfunction

   // Prescaler; tick is registered one count early so it lines up with DIVIDE-1.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else if (!enable_i) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
         r_tick  <= (r_presc == PRESC_PRE);
      end
   end

   assign w_tick = r_tick & enable_i;

   // Round-robin search starting just above the last owner.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_sel_idx   = (req_i[rr_index(r_last, i)] && !w_sel_found) ? rr_index(r_last, i) : w_sel_idx;
         w_sel_found = w_sel_found | req_i[rr_index(r_last, i)];
      end
   end

   assign w_sel_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
   assign w_sel_interval = interval_i[w_sel_idx*WORD_LENGTH +: WORD_LENGTH];
   assign w_count_inc    = r_count + WORD_LENGTH'(1);

`ifdef SAMPLE_SCHEDULER_RELEASE_ABORT_EN
   assign w_release = ((r_grant & req_i) == '0);
`else
   assign w_release = 1'b0;
`endif

   assign w_cancel   = abort_i | w_release;
   assign w_complete = (r_interval == '0) || (w_tick && (w_count_inc == r_interval));

   // FSM state register.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: disable beats cancel beats completion.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable_i && w_sel_found) begin
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!enable_i) begin
               w_state_next = ST_IDLE;
            end else if (w_cancel) begin
               w_state_next = ST_IDLE;
            end else if (w_complete) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_RUN;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: done pulses in the completing cycle itself.
   always_comb begin
      w_done = '0;
      case (r_state)
         ST_RUN: begin
            if (enable_i && !w_cancel && w_complete) begin
               w_done = r_grant;
            end else begin
               w_done = '0;
            end
         end
         default: begin
            w_done = '0;
         end
      endcase
   end

   // Grant, latched interval, tick count and round-robin pointer.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_interval  <= '0;
         r_count     <= '0;
         r_last      <= IW'(NUM_REQ - 1);
      end else if (!enable_i) begin
         r_grant <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_found) begin
                  r_grant     <= w_sel_onehot;
                  r_grant_idx <= w_sel_idx;
                  r_interval  <= w_sel_interval;
                  r_count     <= '0;
               end
            end
            ST_RUN: begin
               if (w_cancel) begin
                  r_grant <= '0;
                  r_count <= '0;
                  r_last  <= r_grant_idx;
               end else if (w_complete) begin
                  r_grant <= '0;
                  r_count <= r_interval;
                  r_last  <= r_grant_idx;
               end else if (w_tick) begin
                  r_count <= w_count_inc;
               end
            end
            default: begin
               r_grant <= '0;
               r_count <= '0;
            end
         endcase
      end
   end

   assign tick_o  = w_tick;
   assign grant_o = r_grant;
   assign done_o  = w_done;
   assign busy_o  = (r_state == ST_RUN);
   assign count_o = r_count;

endmodule

// File: doc/sample_scheduler.md
# sample_scheduler

Shares one sampling-interval timer between `NUM_REQ` requesters. It generates the sampling tick strobe from the system clock, grants the interval counter to one requester at a time in round-robin order, counts that requester's programmed number of ticks, and pulses its `done_o` bit at the end. It sits between the system clock domain logic and the per-channel sampling front-ends, replacing per-channel free-running tick counters.

## Interface

**Parameters**

- `WORD_LENGTH`, 16: width of interval and count values.
- `SYSTEM_FREQUENCY`, 100000000: clock_i frequency in Hz.
- `SAMPLING_FREQUENCY`, 1000000: tick_o rate in Hz. `DIVIDE = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY`, integer, at least 2.
- `NUM_REQ`, 4: number of requesters, from 2 to 8.

**Ports**

- `clock_i`, input, 1: single clock, rising edge.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `enable_i`, input, 1: global enable. Low clears the prescaler and forces IDLE.
- `req_i`, input, NUM_REQ: level request per requester.
- `interval_i`, input, NUM_REQ*WORD_LENGTH: requester k's tick count in bits [k*W +: W].
- `abort_i`, input, 1: cancels the active interval.
- `tick_o`, output, 1: one-cycle strobe every DIVIDE cycles.
- `grant_o`, output, NUM_REQ: one-hot owner of the counter. Zero when idle.
- `done_o`, output, NUM_REQ: one-cycle completion pulse to the granted requester.
- `busy_o`, output, 1: high in RUN.
- `count_o`, output, WORD_LENGTH: ticks elapsed in the current interval.

## Operation

**Prescaler**
- Counter runs 0..DIVIDE-1 while enable_i is high.
- tick_o is high in the cycle the counter holds DIVIDE-1; the counter wraps to 0 on the next edge.
- enable_i low: counter is held at 0 and tick_o is low.

**FSM**

IDLE:
- If enable_i is high and any req_i is set, select the first set bit searching upward from `last+1` (mod NUM_REQ).
- Register grant_o and the selected interval_i slice, clear count_o, and go to RUN.
- Otherwise stay in IDLE.

RUN:
- If the latched interval is 0, pulse done_o at the first RUN cycle and go to IDLE.
- Otherwise count_o increments on each cycle where tick_o is high.
- When the increment reaches the latched interval, pulse done_o[g] in that same cycle, clear grant_o, set `last=g`, and go to IDLE.

Abort:
- abort_i high in RUN means go to IDLE next edge, with no done_o, and set `last=g`.
- abort_i is ignored in IDLE.

Disable:
- enable_i low in any state means IDLE next edge.
- No done_o, grant_o cleared, count_o cleared, `last` unchanged.

Priority of simultaneous events in RUN:
1. enable_i low
2. abort_i
3. completion tick

A tick that coincides with an abort does not produce done_o.

Other rules:
- The interval is latched at grant. Changes to interval_i during RUN have no effect.
- count_o never wraps. The maximum interval is 2^W-1.
- A req_i drop during RUN is ignored unless the configuration macro is defined (see Configuration).

## Timing

- Reset values: tick_o=0, grant_o=0, done_o=0, busy_o=0, count_o=0, FSM=IDLE, prescaler=0, `last=NUM_REQ-1` (so requester 0 is first).
- Grant latency: req_i sampled high in IDLE gives grant_o and busy_o the next cycle.
- First tick_o comes DIVIDE cycles after enable_i rises.
- The prescaler is free-running and not aligned to grant. The first counted tick arrives 1..DIVIDE cycles after grant.
- done_o is coincident with the Nth tick_o. grant_o and busy_o fall the following cycle.
- The earliest regrant is the cycle after done: one IDLE cycle, then the next grant.
- Requesters drop req_i on done_o. A held req_i competes again at lowest priority.

## Configuration

- `SAMPLE_SCHEDULER_RELEASE_ABORT_EN`
  - **Defined:** deassertion of the granted requester's req_i during RUN behaves exactly as abort_i (IDLE next edge, no done_o, `last=g`).
  - **Undefined:** req_i is sampled only in IDLE, and the active interval always runs to completion, abort, or disable.

## Test plan

All scenarios use SYSTEM_FREQUENCY=10 and SAMPLING_FREQUENCY=1 (DIVIDE=10), with NUM_REQ=4 and WORD_LENGTH=16.

1. **Reset and tick:** reset_n_i low mid-RUN, then release with enable_i=1 -> all outputs 0 immediately. tick_o pulses 1 cycle wide every 10 cycles, first pulse at cycle 10.
2. **Single interval:** req_i=0001, interval0=3 -> grant_o=0001 after 1 cycle. count_o steps 1,2,3 on ticks. done_o=0001 for exactly 1 cycle on the 3rd tick. busy_o is low the next cycle.
3. **Round-robin:** req_i=0101 held, intervals=1 -> grant sequence 0,2,0,2, with exactly one IDLE cycle between grants.
4. **Abort:** interval=5, abort_i pulsed after 2 ticks -> no done_o, count_o=0, grant_o=0 next cycle. The next grant goes to the next requester. Abort coincident with a completion tick gives no done_o.
5. **Zero interval and interval change:** interval0=0 -> done_o[0] one cycle after grant. A second run with interval0=2, changed to 9 mid-RUN -> done on the 2nd tick.
6. **Disable mid-run:** enable_i low during RUN -> IDLE next cycle, no done_o, prescaler at 0. On re-enable, the first tick comes 10 cycles later. With the macro defined, dropping req_i mid-RUN gives the same result as an abort.
